id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL provide parameter NOP_INSTR, default 32'h00000013, bubble instruction loaded into instr_e on bubble/flush/reset.
REQ-002 SHALL use one clock; reset is synchronous and active-high: ports clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-003 SHALL provide: instr_d  input  32  fetched instruction in decode; pc_d  input  32  its PC; valid_d  input  1  decode slot holds a real instruction.
REQ-004 SHALL provide: stall  input  1  downstream hold, E registers freeze; flush  input  1  kill decode slot (branch/jump redirect).
REQ-005 SHALL provide: ra1, ra2  output  5  register-file read addresses; rd1, rd2  input  32  register-file read data (x0 reads 0).
REQ-006 SHALL provide: wb_we  input  1, wb_wa  input  5, wb_wd  input  32  writeback port currently driving the register file.
REQ-007 SHALL provide: hazard_d  output  1  upstream must hold fetch/decode this cycle.
REQ-008 SHALL provide registered outputs: valid_e 1, instr_e 32, pc_e 32, rs1_val_e 32, rs2_val_e 32, imm_e 32, rs1_e 5, rs2_e 5, rd_e 5, is_load_e 1.

Function
REQ-009 ra1 SHALL equal instr_d[19:15] and ra2 instr_d[24:20], combinationally, every cycle.
REQ-010 rs1 "used" SHALL be all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111; rs2 "used" SHALL be only R 0110011, S 0100011, B 1100011.
REQ-011 Immediate SHALL be sign-extended per RV32I: I (0010011, 0000011, 1100111), S, B (bit0=0), U (low 12 bits 0), J (bit0=0); any other opcode yields 0.
REQ-012 Load-use hazard SHALL assert when valid_d, !flush, valid_e, is_load_e, rd_e!=0, and rd_e equals a used source of instr_d.
REQ-013 hazard_d SHALL be combinational and equal the load-use hazard OR (per REQ-022) the writeback hazard.
REQ-014 Update priority at each rising edge SHALL be: reset > flush > stall > hazard_d > normal load.
REQ-015 flush SHALL load a bubble: valid_e=0, instr_e=NOP_INSTR, all other E registers 0, even if stall is high.
REQ-016 stall (no flush) SHALL hold every E register unchanged; hazard_d still evaluates from current values.
REQ-017 hazard_d (no flush/stall) SHALL load a bubble as in REQ-015; decode inputs are expected to be held upstream and re-presented next cycle.
REQ-018 Normal load SHALL capture valid_e=valid_d, instr_d, pc_d, source values, imm, fields, is_load_e=(opcode==0000011); latency decode->E is exactly one cycle.
REQ-019 valid_d=0 on normal load SHALL still capture fields but set valid_e=0; a valid_e=0 slot SHALL never cause a hazard.
REQ-020 Register index 0 SHALL never match for hazard or bypass purposes.

Reset
REQ-021 While reset is high at a clock edge, all E outputs SHALL become 0 except instr_e=NOP_INSTR; hazard_d SHALL read 0 the cycle after reset since valid_e=0.

Configuration
REQ-022 Macro ID_WB_BYPASS_EN: when defined, source value SHALL be wb_wd if wb_we and wb_wa!=0 and wb_wa equals the source index, else rdN; when undefined, source value SHALL be rdN, and a writeback hazard (wb_we, wb_wa!=0, wb_wa equals a used source, valid_d, !flush) SHALL additionally assert hazard_d.

Verification
REQ-023 Reset then ADDI x1,x0,5 (0x00500093) valid_d=1 -> next cycle valid_e=1, imm_e=5, rd_e=1, rs1_val_e=0, hazard_d=0.
REQ-024 LW x2,0(x1) then ADD x3,x2,x2 -> hazard_d=1 for one cycle, one bubble (valid_e=0, instr_e=0x00000013), then ADD captured with valid_e=1.
REQ-025 BEQ imm -4 (0xFE000EE3) -> imm_e=0xFFFFFFFC; JAL imm +2048 -> imm_e=0x00000800; LUI 0x12345 -> imm_e=0x12345000.
REQ-026 stall=1 for 3 cycles with changing instr_d -> E outputs unchanged; flush=1 together with stall=1 -> bubble loaded.
REQ-027 With ID_WB_BYPASS_EN: wb_we=1, wb_wa=5, wb_wd=0xDEADBEEF, decode ADD x6,x5,x0, rd1=0 -> rs1_val_e=0xDEADBEEF; without macro -> hazard_d=1, bubble inserted; wb_wa=0 -> no bypass, no hazard.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decode slot, pipeline control, register-file
// read and writeback ports, and the registered execute-stage outputs.
// Pure wiring: no latency, no storage; hold/kill is signalled by stall/flush.
//
// Modports:
//   master - upstream pipeline/regfile side: drives decode, control, read data,
//            writeback; observes read addresses, hazard_d and E outputs.
//   slave  - the id_ex_stage itself.
interface id_ex_stage_if;
    // decode slot
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    // pipeline control
    logic        stall;
    logic        flush;
    logic        hazard_d;
    // register file read
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    // writeback port currently driving the register file
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    // execute-stage registers
    logic        valid_e;
    logic [31:0] instr_e;
    logic [31:0] pc_e;
    logic [31:0] rs1_val_e;
    logic [31:0] rs2_val_e;
    logic [31:0] imm_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic        is_load_e;

    modport master (
        output instr_d, pc_d, valid_d, stall, flush, rd1, rd2,
               wb_we, wb_wa, wb_wd,
        input  hazard_d, ra1, ra2, valid_e, instr_e, pc_e, rs1_val_e,
               rs2_val_e, imm_e, rs1_e, rs2_e, rd_e, is_load_e
    );

    modport slave (
        input  instr_d, pc_d, valid_d, stall, flush, rd1, rd2,
               wb_we, wb_wa, wb_wd,
        output hazard_d, ra1, ra2, valid_e, instr_e, pc_e, rs1_val_e,
               rs2_val_e, imm_e, rs1_e, rs2_e, rd_e, is_load_e
    );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode->execute pipeline register with immediate generation and load-use detection.
// Latency: one cycle decode->E; ra1/ra2 and hazard_d are combinational.
// Backpressure: stall freezes E; hazard_d asks upstream to hold while a bubble is inserted.
//
// Ports: clk, reset (synchronous, active-high), bus (id_ex_stage_if.slave).
// Option: define ID_WB_BYPASS_EN to forward the writeback value into the source
// operands; otherwise a writeback/source collision raises hazard_d instead.
module id_ex_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] imm;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        load_use;
    logic        wb_hazard;

    assign instr  = bus.instr_d;
    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    assign bus.ra1 = rs1;
    assign bus.ra2 = rs2;

    // Unknown opcodes are treated as reading rs1 so they can never slip past a
    // pending load unnoticed.
    assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    always_comb begin
        imm = 32'd0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'd0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

    // A killed or empty decode slot never needs to wait; x0 never matches.
    assign load_use = bus.valid_d && !bus.flush && bus.valid_e && bus.is_load_e &&
                      (bus.rd_e != 5'd0) &&
                      ((rs1_used && (bus.rd_e == rs1)) || (rs2_used && (bus.rd_e == rs2)));

`ifdef ID_WB_BYPASS_EN
    // Register file writes at the end of this cycle, so its read data is stale
    // for the index being written; take the writeback value directly.
    assign src1 = (bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == rs1)) ? bus.wb_wd : bus.rd1;
    assign src2 = (bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == rs2)) ? bus.wb_wd : bus.rd2;
    assign wb_hazard = 1'b0;
`else
    // Without forwarding, wait one cycle until the write has landed.
    assign src1 = bus.rd1;
    assign src2 = bus.rd2;
    assign wb_hazard = bus.wb_we && (bus.wb_wa != 5'd0) && bus.valid_d && !bus.flush &&
                       ((rs1_used && (bus.wb_wa == rs1)) || (rs2_used && (bus.wb_wa == rs2)));
`endif

    assign bus.hazard_d = load_use || wb_hazard;

    // reset > flush > stall > hazard > load
    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.stall && bus.hazard_d)) begin
            bus.valid_e   <= 1'b0;
            bus.instr_e   <= NOP_INSTR;
            bus.pc_e      <= 32'd0;
            bus.rs1_val_e <= 32'd0;
            bus.rs2_val_e <= 32'd0;
            bus.imm_e     <= 32'd0;
            bus.rs1_e     <= 5'd0;
            bus.rs2_e     <= 5'd0;
            bus.rd_e      <= 5'd0;
            bus.is_load_e <= 1'b0;
        end else if (!bus.stall) begin
            bus.valid_e   <= bus.valid_d;
            bus.instr_e   <= instr;
            bus.pc_e      <= bus.pc_d;
            bus.rs1_val_e <= src1;
            bus.rs2_val_e <= src2;
            bus.imm_e     <= imm;
            bus.rs1_e     <= rs1;
            bus.rs2_e     <= rs2;
            bus.rd_e      <= rd;
            bus.is_load_e <= (opcode == OP_LOAD);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, field capture, immediates, load-use
// bubble, stall/flush priority and writeback collision handling.
// Inputs change #1 after the rising edge; outputs are checked before the next edge.
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    id_ex_stage_if bus ();

    id_ex_stage #(.NOP_INSTR(32'h00000013)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] ADDI_X1  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] LW_X2    = 32'h0000A103; // lw x2,0(x1)
    localparam logic [31:0] LW_X0    = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADD_X3   = 32'h002101B3; // add x3,x2,x2
    localparam logic [31:0] ADD_X0   = 32'h000001B3; // add x3,x0,x0
    localparam logic [31:0] ADDI_X4  = 32'h00208213; // addi x4,x1,2 (rs2 field = 2, unused)
    localparam logic [31:0] ADDI_M1  = 32'hFFF00093; // addi x1,x0,-1
    localparam logic [31:0] ADD_X6   = 32'h00028333; // add x6,x5,x0
    localparam logic [31:0] ADD_X600 = 32'h00000333; // add x6,x0,x0

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc, input logic vld,
                           input logic [31:0] r1, input logic [31:0] r2);
        bus.instr_d = ins;
        bus.pc_d    = pc;
        bus.valid_d = vld;
        bus.rd1     = r1;
        bus.rd2     = r2;
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.valid_e}, 32'd0);
        chk({tag, ".instr"}, bus.instr_e, NOP);
        chk({tag, ".pc"}, bus.pc_e, 32'd0);
        chk({tag, ".imm"}, bus.imm_e, 32'd0);
        chk({tag, ".rd"}, {27'd0, bus.rd_e}, 32'd0);
        chk({tag, ".load"}, {31'd0, bus.is_load_e}, 32'd0);
    endtask

    logic [31:0] imm_ins [6];
    logic [31:0] imm_exp [6];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.wb_we = 1'b0;
        bus.wb_wa = 5'd0;
        bus.wb_wd = 32'd0;
        present(LW_X2, 32'h0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        reset = 1'b0;

        // reset state
        chk_bubble("rst");
        chk("rst.rs1val", bus.rs1_val_e, 32'd0);
        present(ADD_X3, 32'h0, 1'b1, 32'd0, 32'd0);
        chk("rst.hazard", {31'd0, bus.hazard_d}, 32'd0);

        // ADDI x1,x0,5
        present(ADDI_X1, 32'h100, 1'b1, 32'd0, 32'h77);
        chk("addi.ra1", {27'd0, bus.ra1}, 32'd0);
        chk("addi.ra2", {27'd0, bus.ra2}, 32'd5);
        chk("addi.hazard", {31'd0, bus.hazard_d}, 32'd0);
        step();
        chk("addi.valid", {31'd0, bus.valid_e}, 32'd1);
        chk("addi.imm", bus.imm_e, 32'd5);
        chk("addi.rd", {27'd0, bus.rd_e}, 32'd1);
        chk("addi.rs1val", bus.rs1_val_e, 32'd0);
        chk("addi.pc", bus.pc_e, 32'h100);
        chk("addi.instr", bus.instr_e, ADDI_X1);

        // LW x2 then ADD x3,x2,x2: one bubble
        present(LW_X2, 32'h104, 1'b1, 32'h1000, 32'd0);
        chk("lw.hazard", {31'd0, bus.hazard_d}, 32'd0);
        step();
        chk("lw.load", {31'd0, bus.is_load_e}, 32'd1);
        chk("lw.rd", {27'd0, bus.rd_e}, 32'd2);
        chk("lw.rs1val", bus.rs1_val_e, 32'h1000);
        present(ADD_X3, 32'h108, 1'b1, 32'h2222, 32'h2222);
        chk("lu.hazard", {31'd0, bus.hazard_d}, 32'd1);
        step();
        chk_bubble("lu.bub");
        chk("lu.hazard2", {31'd0, bus.hazard_d}, 32'd0);
        step();
        chk("lu.valid", {31'd0, bus.valid_e}, 32'd1);
        chk("lu.instr", bus.instr_e, ADD_X3);
        chk("lu.rs1val", bus.rs1_val_e, 32'h2222);
        chk("lu.rs2val", bus.rs2_val_e, 32'h2222);
        chk("lu.rd", {27'd0, bus.rd_e}, 32'd3);

        // load to x0 never matches
        present(LW_X0, 32'h10C, 1'b1, 32'd0, 32'd0);
        step();
        present(ADD_X0, 32'h110, 1'b1, 32'd0, 32'd0);
        chk("x0.hazard", {31'd0, bus.hazard_d}, 32'd0);

        // invalid load slot: fields captured, no hazard
        present(LW_X2, 32'h114, 1'b0, 32'd0, 32'd0);
        step();
        chk("inv.valid", {31'd0, bus.valid_e}, 32'd0);
        chk("inv.load", {31'd0, bus.is_load_e}, 32'd1);
        chk("inv.rd", {27'd0, bus.rd_e}, 32'd2);
        present(ADD_X3, 32'h118, 1'b1, 32'd0, 32'd0);
        chk("inv.hazard", {31'd0, bus.hazard_d}, 32'd0);

        // unused rs2 field must not match a pending load
        present(LW_X2, 32'h11C, 1'b1, 32'd0, 32'd0);
        step();
        present(ADDI_X4, 32'h120, 1'b1, 32'd0, 32'd0);
        chk("rs2u.hazard", {31'd0, bus.hazard_d}, 32'd0);
        step();

        // immediates
        imm_ins[0] = 32'hFE000EE3; imm_exp[0] = 32'hFFFFFFFC; // beq -4
        imm_ins[1] = 32'h0010006F; imm_exp[1] = 32'h00000800; // jal +2048
        imm_ins[2] = 32'h123452B7; imm_exp[2] = 32'h12345000; // lui
        imm_ins[3] = 32'hFE20AC23; imm_exp[3] = 32'hFFFFFFF8; // sw -8
        imm_ins[4] = ADDI_M1;      imm_exp[4] = 32'hFFFFFFFF; // addi -1
        imm_ins[5] = 32'h8000000F; imm_exp[5] = 32'h00000000; // other opcode
        for (int i = 0; i < 6; i++) begin
            present(imm_ins[i], 32'h200 + 32'(i * 4), 1'b1, 32'd0, 32'd0);
            step();
            chk($sformatf("imm%0d", i), bus.imm_e, imm_exp[i]);
        end

        // stall holds for 3 cycles, then flush wins over stall
        present(ADDI_M1, 32'h300, 1'b1, 32'd0, 32'd0);
        step();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(32'h00A00113 + 32'(i << 20), 32'h400 + 32'(i * 4), 1'b1, 32'h9, 32'h9);
            step();
            chk($sformatf("stall%0d.instr", i), bus.instr_e, ADDI_M1);
            chk($sformatf("stall%0d.pc", i), bus.pc_e, 32'h300);
            chk($sformatf("stall%0d.imm", i), bus.imm_e, 32'hFFFFFFFF);
            chk($sformatf("stall%0d.valid", i), {31'd0, bus.valid_e}, 32'd1);
        end
        bus.flush = 1'b1;
        #1;
        step();
        chk_bubble("flst");
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // hazard still evaluates under stall; flush suppresses it
        present(LW_X2, 32'h500, 1'b1, 32'd0, 32'd0);
        step();
        bus.stall = 1'b1;
        present(ADD_X3, 32'h504, 1'b1, 32'd0, 32'd0);
        chk("sth.hazard", {31'd0, bus.hazard_d}, 32'd1);
        step();
        chk("sth.load", {31'd0, bus.is_load_e}, 32'd1);
        chk("sth.rd", {27'd0, bus.rd_e}, 32'd2);
        bus.flush = 1'b1;
        #1;
        chk("fl.hazard", {31'd0, bus.hazard_d}, 32'd0);
        step();
        chk_bubble("fl.bub");
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // writeback collision on rs1
        bus.wb_we = 1'b1;
        bus.wb_wa = 5'd5;
        bus.wb_wd = 32'hDEADBEEF;
        present(ADD_X6, 32'h600, 1'b1, 32'd0, 32'd0);
`ifdef ID_WB_BYPASS_EN
        chk("wb.hazard", {31'd0, bus.hazard_d}, 32'd0);
        step();
        chk("wb.valid", {31'd0, bus.valid_e}, 32'd1);
        chk("wb.rs1val", bus.rs1_val_e, 32'hDEADBEEF);
`else
        chk("wb.hazard", {31'd0, bus.hazard_d}, 32'd1);
        step();
        chk_bubble("wb.bub");
        bus.wb_we = 1'b0;
        present(ADD_X6, 32'h600, 1'b1, 32'h55, 32'd0);
        chk("wb.hazard2", {31'd0, bus.hazard_d}, 32'd0);
        step();
        chk("wb.valid", {31'd0, bus.valid_e}, 32'd1);
        chk("wb.rs1val", bus.rs1_val_e, 32'h55);
`endif
        // writeback to x0: no bypass, no hazard
        bus.wb_we = 1'b1;
        bus.wb_wa = 5'd0;
        present(ADD_X600, 32'h604, 1'b1, 32'd0, 32'd0);
        chk("wb0.hazard", {31'd0, bus.hazard_d}, 32'd0);
        step();
        chk("wb0.valid", {31'd0, bus.valid_e}, 32'd1);
        chk("wb0.rs1val", bus.rs1_val_e, 32'd0);
        bus.wb_we = 1'b0;

        // reset mid-stream
        present(ADDI_X1, 32'h700, 1'b1, 32'd0, 32'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_bubble("rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
